// File: rtl/decompose_w1_mem_ctrl_if.sv
// Request/beat handshakes and buffer port of the decompose z-bit buffer controller.
interface decompose_w1_mem_ctrl_if #(
  parameter int NUM_POLY   = 8,
  parameter int POLY_DEPTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 4
);
  localparam int PW = $clog2(NUM_POLY);

  logic                  wr_start;
  logic [PW-1:0]         wr_poly;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  wr_done;
  logic                  rd_start;
  logic [PW-1:0]         rd_poly;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ready;
  logic                  rd_done;
  logic                  req_err;
  logic [NUM_POLY-1:0]   poly_valid;
  logic                  busy;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  wr_start, wr_poly, wr_valid, wr_data, rd_start, rd_poly, rd_ready, mem_dout,
    output wr_ready, wr_done, rd_valid, rd_data, rd_done, req_err, poly_valid, busy,
           mem_rden, mem_wren, mem_addr, mem_din
  );

  modport master (
    output wr_start, wr_poly, wr_valid, wr_data, rd_start, rd_poly, rd_ready, mem_dout,
    input  wr_ready, wr_done, rd_valid, rd_data, rd_done, req_err, poly_valid, busy,
           mem_rden, mem_wren, mem_addr, mem_din
  );
endinterface

// File: rtl/decompose_w1_mem_ctrl.sv
// Sequencer/arbiter sharing the decompose z-bit buffer between the decompose
// writer and the makehint reader, with one-deep request queues per side.
module decompose_w1_mem_ctrl #(
  parameter int NUM_POLY   = 8,
  parameter int POLY_DEPTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic zeroize,
  decompose_w1_mem_ctrl_if.slave bus
);
  localparam int PW = $clog2(NUM_POLY);
  localparam int CW = $clog2(POLY_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t              state, state_nxt;
  logic                clr;
  logic                wr_pend, rd_pend;
  logic [PW-1:0]       wr_pend_poly, rd_pend_poly, cur_poly;
  logic                wr_req, rd_req;
  logic [PW-1:0]       wr_req_poly, rd_req_poly;
  logic [CW-1:0]       wr_cnt, rd_cnt;
  logic [CW:0]         issue_cnt;
  logic                rd_valid_q, wr_done_q, rd_done_q, req_err_q;
  logic [NUM_POLY-1:0] poly_valid_q;
  logic                wr_ready, wr_beat, rd_beat, rden;
  logic [ADDR_WIDTH-1:0] addr;

  assign clr = !reset_n || zeroize;

  // Effective request: the pending entry, otherwise a start arriving now.
  assign wr_req      = wr_pend || bus.wr_start;
  assign wr_req_poly = wr_pend ? wr_pend_poly : bus.wr_poly;
  assign rd_req      = rd_pend || bus.rd_start;
  assign rd_req_poly = rd_pend ? rd_pend_poly : bus.rd_poly;

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: writes win; a read waits until its poly holds valid data.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_req) state_nxt = WRITE;
        else if (rd_req && poly_valid_q[rd_req_poly]) state_nxt = READ;
      end
      WRITE:   if (wr_beat && wr_cnt == CW'(POLY_DEPTH - 1)) state_nxt = IDLE;
      READ:    if (rd_beat && rd_cnt == CW'(POLY_DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer port and handshake decode for the current state.
  always_comb begin
    wr_ready = 1'b0;
    wr_beat  = 1'b0;
    rd_beat  = 1'b0;
    rden     = 1'b0;
    addr     = '0;
    case (state)
      WRITE: begin
        wr_ready = 1'b1;
        wr_beat  = bus.wr_valid;
        addr     = ADDR_WIDTH'({cur_poly, wr_cnt});
      end
      READ: begin
        rden    = (issue_cnt < (CW+1)'(POLY_DEPTH)) && (!rd_valid_q || bus.rd_ready);
        rd_beat = rd_valid_q && bus.rd_ready;
        addr    = ADDR_WIDTH'({cur_poly, issue_cnt[CW-1:0]});
      end
      default: ;
    endcase
  end

  // Queues, counters, read-valid tracking, poly_valid and pulse outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      wr_pend_poly <= '0;
      rd_pend_poly <= '0;
      cur_poly     <= '0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      issue_cnt    <= '0;
      rd_valid_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      req_err_q    <= 1'b0;
      poly_valid_q <= '0;
    end else begin
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      req_err_q <= (bus.wr_start && wr_pend) || (bus.rd_start && rd_pend);
      if (bus.wr_start && !wr_pend) begin
        wr_pend      <= 1'b1;
        wr_pend_poly <= bus.wr_poly;
      end
      if (bus.rd_start && !rd_pend) begin
        rd_pend      <= 1'b1;
        rd_pend_poly <= bus.rd_poly;
      end
      case (state)
        IDLE: begin
          // A dispatch clears the queue even when the entry was this cycle's start.
          if (state_nxt == WRITE) begin
            wr_pend                   <= 1'b0;
            cur_poly                  <= wr_req_poly;
            wr_cnt                    <= '0;
            poly_valid_q[wr_req_poly] <= 1'b0;
          end else if (state_nxt == READ) begin
            rd_pend    <= 1'b0;
            cur_poly   <= rd_req_poly;
            issue_cnt  <= '0;
            rd_cnt     <= '0;
            rd_valid_q <= 1'b0;
          end
        end
        WRITE: begin
          if (wr_beat) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (state_nxt == IDLE) begin
              wr_done_q              <= 1'b1;
              poly_valid_q[cur_poly] <= 1'b1;
            end
          end
        end
        READ: begin
          if (rden) begin
            issue_cnt  <= issue_cnt + 1'b1;
            rd_valid_q <= 1'b1;
          end else if (rd_beat) begin
            rd_valid_q <= 1'b0;
          end
          if (rd_beat) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (state_nxt == IDLE) rd_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.wr_done    = wr_done_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_valid_q ? bus.mem_dout : DATA_WIDTH'(0);
  assign bus.rd_done    = rd_done_q;
  assign bus.req_err    = req_err_q;
  assign bus.poly_valid = poly_valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.mem_rden   = rden;
  assign bus.mem_wren   = wr_beat;
  assign bus.mem_addr   = addr;
  assign bus.mem_din    = bus.wr_data;
endmodule

// File: tb/tb_decompose_w1_mem_ctrl.sv
// Directed sequence with randomized data/backpressure for decompose_w1_mem_ctrl,
// checked against a per-poly content model and expected valid map.
module tb_decompose_w1_mem_ctrl;
  logic clk;
  logic reset_n;
  logic zeroize;
  int   n_tests = 0;
  int   n_fail  = 0;

  decompose_w1_mem_ctrl_if #(.NUM_POLY(8), .POLY_DEPTH(64), .ADDR_WIDTH(9), .DATA_WIDTH(4)) bus ();

  decompose_w1_mem_ctrl #(.NUM_POLY(8), .POLY_DEPTH(64), .ADDR_WIDTH(9), .DATA_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer: registered read, dout held while rden is low.
  logic [3:0] buf_mem [512];
  always @(posedge clk) begin
    if (bus.mem_wren) buf_mem[bus.mem_addr] <= bus.mem_din;
    if (bus.mem_rden) bus.mem_dout <= buf_mem[bus.mem_addr];
  end

  // Reference: what each poly should contain, and which polys are complete.
  logic [3:0] mdl [8][64];
  logic [7:0] exp_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_wr_ready"}, bus.wr_ready, 0);
    chk({tag, "_wr_done"}, bus.wr_done, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
    chk({tag, "_rd_done"}, bus.rd_done, 0);
    chk({tag, "_req_err"}, bus.req_err, 0);
    chk({tag, "_poly_valid"}, bus.poly_valid, 0);
    chk({tag, "_mem_rden"}, bus.mem_rden, 0);
    chk({tag, "_mem_wren"}, bus.mem_wren, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_din"}, bus.mem_din, 0);
  endtask

  // Writes poly p; optionally queues a second write at loop step pend_at and
  // tries a dropped one at drop_at (negative disables).
  task automatic write_poly(input int p, input bit do_start, input bit pattern, input bit gaps,
                            input int pend_at, input int pend_p, input int drop_at, input int drop_p);
    logic [3:0] d [64];
    int i, k;
    bit v;
    for (int j = 0; j < 64; j++) d[j] = pattern ? 4'(j) : 4'($urandom);
    if (do_start) begin
      bus.wr_start = 1'b1;
      bus.wr_poly  = 3'(p);
    end
    @(negedge clk);
    bus.wr_start = 1'b0;
    bus.rd_start = 1'b0;
    exp_valid[p] = 1'b0;
    i = 0;
    k = 0;
    while (i < 64 && k < 400) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wr_valid = v;
      bus.wr_data  = d[i];
      bus.wr_start = (k == pend_at) || (k == drop_at);
      bus.wr_poly  = (k == drop_at) ? 3'(drop_p) : 3'(pend_p);
      #1;
      chk("wr_ready", bus.wr_ready, 1);
      chk("wr_done_early", bus.wr_done, 0);
      chk("wr_busy", bus.busy, 1);
      chk("wr_mem_wren", bus.mem_wren, v);
      if (v) begin
        chk("wr_addr", bus.mem_addr, p * 64 + i);
        chk("wr_din", bus.mem_din, d[i]);
      end
      chk("req_err", bus.req_err, (drop_at >= 0 && k == drop_at + 1) ? 1 : 0);
      @(negedge clk);
      if (v) i++;
      k++;
    end
    bus.wr_valid = 1'b0;
    bus.wr_start = 1'b0;
    bus.wr_data  = '0;
    if (!gaps) chk("wr_latency", k, 64);
    chk("wr_finished", i, 64);
    for (int j = 0; j < 64; j++) mdl[p][j] = d[j];
    exp_valid[p] = 1'b1;
    #1;
    chk("wr_done", bus.wr_done, 1);
    chk("wr_poly_valid", bus.poly_valid, exp_valid);
    chk("wr_busy_after", bus.busy, 0);
  endtask

  // Reads poly p; mode 0 = always ready, 1 = ready toggling 1010.., 2 = random.
  task automatic read_poly(input int p, input bit do_start, input int mode);
    logic [3:0] held;
    bit stalled, r;
    int got, k;
    if (do_start) begin
      bus.rd_start = 1'b1;
      bus.rd_poly  = 3'(p);
    end
    @(negedge clk);
    bus.rd_start = 1'b0;
    got = 0;
    k = 0;
    stalled = 1'b0;
    held = '0;
    while (got < 64 && k < 400) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      bus.rd_ready = r;
      #1;
      chk("rd_no_wren", bus.mem_wren, 0);
      chk("rd_done_early", bus.rd_done, 0);
      if (stalled) begin
        chk("rd_hold_valid", bus.rd_valid, 1);
        chk("rd_hold_data", bus.rd_data, held);
      end
      if (bus.rd_valid === 1'b1) begin
        if (r) begin
          chk("rd_data", bus.rd_data, mdl[p][got]);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = bus.rd_data;
        end
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.rd_ready = 1'b0;
    if (mode == 0) chk("rd_latency", k, 65);
    chk("rd_finished", got, 64);
    #1;
    chk("rd_done", bus.rd_done, 1);
    chk("rd_valid_off", bus.rd_valid, 0);
    chk("rd_poly_valid", bus.poly_valid, exp_valid);
  endtask

  initial begin
    reset_n      = 1'b0;
    zeroize      = 1'b0;
    bus.wr_start = 1'b0;
    bus.wr_poly  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_start = 1'b0;
    bus.rd_poly  = '0;
    bus.rd_ready = 1'b0;
    exp_valid    = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Poly 3 with data = addr[3:0], then streamed back.
    write_poly(3, 1, 1, 0, -1, 0, -1, 0);
    chk("poly_valid_08", bus.poly_valid, 8'h08);
    @(negedge clk);
    #1;
    chk("wr_done_one_cycle", bus.wr_done, 0);
    read_poly(3, 1, 0);
    chk("poly_valid_after_read", bus.poly_valid, 8'h08);
    read_poly(3, 1, 1);

    // Read of invalid poly 5 together with a write of poly 5: write goes first.
    bus.rd_start = 1'b1;
    bus.rd_poly  = 3'd5;
    write_poly(5, 1, 0, 0, -1, 0, -1, 0);
    read_poly(5, 0, 0);

    // Queued second write plus a dropped third one.
    write_poly(1, 1, 0, 1, 5, 2, 10, 6);
    write_poly(2, 0, 0, 1, -1, 0, -1, 0);
    @(negedge clk);
    #1;
    chk("dropped_not_run", bus.busy, 0);
    chk("dropped_valid", bus.poly_valid, exp_valid);
    read_poly(2, 1, 2);

    // Zeroize at beat 30 of a write.
    @(negedge clk);
    bus.wr_start = 1'b1;
    bus.wr_poly  = 3'd4;
    @(negedge clk);
    bus.wr_start = 1'b0;
    for (int b = 0; b < 30; b++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 4'($urandom);
      @(negedge clk);
    end
    bus.wr_valid = 1'b1;
    zeroize = 1'b1;
    @(negedge clk);
    zeroize      = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    exp_valid    = '0;
    #1;
    chk_all_zero("zeroize");
    @(negedge clk);
    #1;
    chk("zeroize_no_done", bus.wr_done, 0);
    write_poly(4, 1, 0, 0, -1, 0, -1, 0);
    read_poly(4, 1, 2);

    // Poly 3 lost its valid bit: its read waits until it is rewritten.
    bus.rd_start = 1'b1;
    bus.rd_poly  = 3'd3;
    repeat (4) begin
      @(negedge clk);
      bus.rd_start = 1'b0;
      #1;
      chk("rd_wait_busy", bus.busy, 0);
      chk("rd_wait_rden", bus.mem_rden, 0);
    end
    write_poly(3, 1, 0, 0, -1, 0, -1, 0);
    read_poly(3, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decompose_w1_mem_ctrl.md
# decompose_w1_mem_ctrl

Sequencer and arbiter for the 512x4 decompose z-bit buffer. It shares the single buffer port between two requesters: the decompose unit, which writes a 64-address polynomial, and makehint, which reads one. It generates the per-poly addresses, tracks which polynomials hold valid z data, and streams read data out with valid/ready backpressure. It sits between the decompose/makehint datapaths and the buffer instance.

## Interface
- NUM_POLY, 8, polynomials held in the buffer
- POLY_DEPTH, 64, addresses per poly (4 coeffs/addr)
- ADDR_WIDTH, 9, buffer address width = log2(NUM_POLY)+log2(POLY_DEPTH)
- DATA_WIDTH, 4, bits per address
- PW (derived), log2(NUM_POLY), width of the poly-index ports

- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- zeroize  in  1  synchronous clear; same effect as reset
- wr_start  in  1  write request pulse
- wr_poly  in  PW  target poly of the write request
- wr_valid  in  1  write beat valid
- wr_data  in  DATA_WIDTH  write beat
- wr_ready  out  1  write beat accepted when wr_valid & wr_ready
- wr_done  out  1  one-cycle pulse: poly fully written
- rd_start  in  1  read request pulse
- rd_poly  in  PW  source poly of the read request
- rd_valid  out  1  read beat valid
- rd_data  out  DATA_WIDTH  read beat
- rd_ready  in  1  consumer accepts the beat
- rd_done  out  1  one-cycle pulse: last read beat accepted
- req_err  out  1  one-cycle pulse: request dropped (one-deep queue full)
- poly_valid  out  NUM_POLY  bit i set when poly i holds completely written data
- busy  out  1  state != IDLE
- mem_rden, mem_wren  out  1 each  to the buffer
- mem_addr  out  ADDR_WIDTH  to the buffer
- mem_din  out  DATA_WIDTH  to the buffer
- mem_dout  in  DATA_WIDTH  from the buffer (registered, 1-cycle latency, holds value when rden=0)

## Operation
- FSM states: IDLE, WRITE, READ.
- Request queues:
  - Each request type has a one-deep pending register (flag + poly).
  - A start pulse loads the queue in any state when that queue is empty.
  - A start pulse with the queue full is dropped and pulses req_err in the following cycle.
- Dispatch (IDLE only). The effective request is the pending entry, or the start pulse arriving this cycle.
  - A write wins whenever present.
  - A read is dispatched only if poly_valid[poly] = 1; otherwise it stays pending, and a write may pass it.
  - The dispatched queue entry is cleared.
- WRITE:
  - poly_valid[poly] is cleared on dispatch.
  - wr_ready = 1 throughout WRITE.
  - On each accepted beat: mem_wren = 1, mem_addr = {poly, cnt}, mem_din = wr_data, cnt++.
  - After beat POLY_DEPTH-1 is accepted: return to IDLE, wr_done pulses, poly_valid[poly] sets.
- READ:
  - mem_rden = READ & (issue_cnt < POLY_DEPTH) & (!rd_valid | rd_ready); mem_addr = {poly, issue_cnt}.
  - rd_valid is set the cycle after mem_rden. It is cleared when the beat is accepted and no new read was issued in that cycle.
  - rd_data = mem_dout, combinational. The buffer holds dout while rden = 0, so stalled data stays stable.
  - After beat POLY_DEPTH-1 is accepted: return to IDLE, rd_done pulses. poly_valid is unchanged (data may be re-read).
- In IDLE: mem_rden = mem_wren = 0 and mem_addr = 0. mem_din = wr_data at all times.
- Reset or zeroize takes priority over all activity, including mid-transfer:
  - State goes to IDLE, and all counters, queues and poly_valid are cleared.
  - All outputs go to 0.
  - The in-flight transfer is abandoned with no done pulse.
  - The controller does not zeroize the buffer; the buffer has its own zeroize input.

## Timing
- Reset values: every output is 0 (wr_ready, wr_done, rd_valid, rd_data, rd_done, req_err, poly_valid, busy, and all mem_* outputs).
- Write: wr_start in cycle t (IDLE, no competing write) -> WRITE and wr_ready = 1 at t+1. With back-to-back beats, the last beat lands at t+64. wr_done and the poly_valid bit appear at t+65, in IDLE.
- Read: rd_start at t with poly valid -> first mem_rden at t+1, first rd_valid at t+2. With rd_ready held at 1, the last beat is at t+65 and rd_done at t+66.
- Throughput is 1 beat/cycle with no bubbles under continuous valid/ready.
- A pending request can dispatch in the same IDLE cycle as the previous done pulse. Its new state starts the next cycle.
- req_err asserts exactly 1 cycle after the dropped start.

## Test plan
- Write poly 3 with data = addr[3:0] for 64 beats -> mem_addr 192..255 with mem_wren; wr_done at t+65; poly_valid = 8'h08.
- Then read poly 3 with rd_ready = 1 -> 64 beats 0,1,..,F repeating; rd_done at t+66; poly_valid unchanged.
- Read of poly 3 with rd_ready toggling 1010.. -> every beat delivered once, in order; rd_data stable while stalled.
- rd_start(poly 5, not valid) and wr_start(poly 5) in the same cycle -> write runs first, then the read dispatches in the wr_done cycle and returns the written data.
- A second wr_start during WRITE with the queue already full -> req_err 1 cycle later; the first pending write still executes.
- zeroize at beat 30 of a write -> next cycle busy = 0, poly_valid = 0, no wr_done, all outputs 0; a new write then starts at cnt 0.
